// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_IDX_W          = 5;
    localparam int unsigned MULDIV_CYCLES_DFLT = 4;
    localparam int unsigned CNT_W              = 4;
    localparam int unsigned PERF_W             = 32;

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_MULDIV = 1'b1;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: an ID source matches a non-zero load destination in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    output logic                 lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs & (id_rs == ex_rd);
    assign rt_hit = id_uses_rt & (id_rt == ex_rd);
    assign lu     = ex_is_load & (ex_rd != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline with a mul/div occupancy sequencer.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DFLT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 id_muldiv,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    input  logic                 ex_branch_taken,
    input  logic                 if_busy,
    input  logic                 mem_busy,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 id_ex_stall,
    output logic                 ex_mem_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
`ifdef PIPE_PERF_CNT_EN
    output logic [PERF_W-1:0]    perf_stall_cycles,
    output logic [PERF_W-1:0]    perf_flush_cycles,
`endif
    output logic                 muldiv_busy
);

    logic             state_q;
    logic             state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lu;
    logic             md;
    logic             id_advance;

    load_use_detect u_load_use_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .lu         (lu)
    );

    assign md          = (state_q == ST_MULDIV) && (cnt_q != '0);
    assign muldiv_busy = (state_q == ST_MULDIV);

    // Priority encoder; reset forces every hazard output low regardless of inputs.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (md) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (lu) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (if_busy) begin
                pc_stall     = 1'b1;
                if_id_flush  = 1'b1;
            end
        end
    end

    // The ID instruction moves into ID/EX only when that transfer is neither held nor squashed.
    assign id_advance = ~if_id_stall & ~id_ex_stall & ~id_ex_flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (id_muldiv && id_advance) begin
                    state_d = ST_MULDIV;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            ST_MULDIV: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else if (!mem_busy) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_flush_q;
    logic              any_flush;

    assign any_flush = if_id_flush | id_ex_flush | ex_mem_flush | mem_wb_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pc_stall) begin
                perf_stall_q <= perf_stall_q + PERF_W'(1);
            end
            if (any_flush) begin
                perf_flush_q <= perf_flush_q + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cycles = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (default MULDIV_CYCLES = 4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, id_muldiv, ex_is_load, ex_branch_taken, if_busy, mem_busy;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, muldiv_busy;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_muldiv       (id_muldiv),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .if_busy         (if_busy),
        .mem_busy        (mem_busy),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .ex_mem_stall    (ex_mem_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
`ifdef PIPE_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cycles (perf_flush_cycles),
`endif
        .muldiv_busy     (muldiv_busy)
    );

    always #5 clk = ~clk;

    // Output order: pc,ifid_s,idex_s,exmem_s, ifid_f,idex_f,exmem_f,memwb_f, busy
    localparam logic [8:0] O_NONE   = 9'b0000_0000_0;
    localparam logic [8:0] O_LU     = 9'b1100_0100_0;
    localparam logic [8:0] O_BR     = 9'b0000_1100_0;
    localparam logic [8:0] O_IFB    = 9'b1000_1000_0;
    localparam logic [8:0] O_MEM    = 9'b1111_0001_0;
    localparam logic [8:0] O_MD     = 9'b1110_0010_1;
    localparam logic [8:0] O_MD_MEM = 9'b1111_0001_1;
    localparam logic [8:0] O_MD_END = 9'b0000_0000_1;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, rd;
        logic       urs, urt, ld, br, ifb, memb;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(string n, logic [4:0] rs, logic urs, logic [4:0] rt, logic urt,
                                logic [4:0] rd, logic ld, logic br, logic ifb, logic memb,
                                logic [8:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.rd = rd;
        v.ld = ld; v.br = br; v.ifb = ifb; v.memb = memb; v.exp = exp;
        return v;
    endfunction

    function automatic logic [8:0] outs();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, muldiv_busy};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_muldiv = 1'b0;
        ex_is_load = 1'b0; ex_branch_taken = 1'b0; if_busy = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        id_rs = v.rs; id_uses_rs = v.urs; id_rt = v.rt; id_uses_rt = v.urt;
        ex_rd = v.rd; ex_is_load = v.ld; ex_branch_taken = v.br;
        if_busy = v.ifb; mem_busy = v.memb; id_muldiv = 1'b0;
    endtask

    // Step to the next falling edge, where inputs change and outputs are sampled.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a mul/div from ID and step into its first EX cycle (cnt = 3).
    task automatic start_muldiv();
        idle_inputs();
        id_muldiv = 1'b1;
        #1 check("md_issue_run", O_NONE);
        next_cycle();
        id_muldiv = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk("idle",          5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, O_NONE);
        vecs[1]  = mk("lu_rs",         5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, O_LU);
        vecs[2]  = mk("lu_rd_zero",    5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, O_NONE);
        vecs[3]  = mk("lu_rt",         5'd1, 1, 5'd9, 1, 5'd9, 1, 0, 0, 0, O_LU);
        vecs[4]  = mk("rt_unused",     5'd1, 1, 5'd9, 0, 5'd9, 1, 0, 0, 0, O_NONE);
        vecs[5]  = mk("not_load",      5'd7, 1, 5'd0, 0, 5'd7, 0, 0, 0, 0, O_NONE);
        vecs[6]  = mk("br_over_lu",    5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, O_BR);
        vecs[7]  = mk("if_busy",       5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, O_IFB);
        vecs[8]  = mk("lu_over_ifb",   5'd3, 0, 5'd3, 1, 5'd3, 1, 0, 1, 0, O_LU);
        vecs[9]  = mk("mem_over_br",   5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 1, O_MEM);
        vecs[10] = mk("br_over_ifb",   5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 0, O_BR);
        vecs[11] = mk("rs_mismatch",   5'd4, 1, 5'd6, 1, 5'd5, 1, 0, 0, 0, O_NONE);

        idle_inputs();
        rst = 1'b1;
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        #2 check("reset_outputs", O_NONE);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            #1 check(vecs[i].name, vecs[i].exp);
            next_cycle();
        end

        // Load-use lasts one cycle: the load has moved on next cycle.
        idle_inputs();
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        #1 check("lu_cycle1", O_LU);
        next_cycle();
        idle_inputs();
        #1 check("lu_cycle2", O_NONE);

        // if_busy held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            if_busy = 1'b1;
            #1 check("if_busy_run", O_IFB);
            next_cycle();
        end
        idle_inputs();

        // Mul/div without memory wait: 3 stall cycles then one busy-only cycle.
        start_muldiv();
        for (int i = 0; i < 3; i++) begin
            #1 check("md_stall", O_MD);
            next_cycle();
        end
        #1 check("md_last", O_MD_END);
        next_cycle();
        #1 check("md_done", O_NONE);
        next_cycle();

        // Mul/div with mem_busy for 2 cycles at cnt=2.
        start_muldiv();
        #1 check("mdm_cnt3", O_MD);
        next_cycle();
        mem_busy = 1'b1;
        #1 check("mdm_mem1", O_MD_MEM);
        next_cycle();
        #1 check("mdm_mem2", O_MD_MEM);
        next_cycle();
        mem_busy = 1'b0;
        #1 check("mdm_cnt2", O_MD);
        next_cycle();
        #1 check("mdm_cnt1", O_MD);
        next_cycle();
        #1 check("mdm_last", O_MD_END);
        next_cycle();
        #1 check("mdm_done", O_NONE);
        next_cycle();

        // Reset during cycle 2 of a mul/div aborts it immediately.
        start_muldiv();
        next_cycle();
        #1 check("rst_pre_md", O_MD);
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        rst = 1'b1;
        #1 check("rst_abort", O_NONE);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        #1 check("rst_no_residual", O_NONE);
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (perf_stall_cycles !== 32'd0 || perf_flush_cycles !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_stall_cycles, perf_flush_cycles);
        end
        if_busy = 1'b1;
        next_cycle();
        if_busy = 1'b0;
        #1;
        checks++;
        if (perf_stall_cycles !== 32'd1 || perf_flush_cycles !== 32'd1) begin
            failures++;
            $display("FAIL perf_count: got %0d/%0d expected 1/1", perf_stall_cycles, perf_flush_cycles);
        end
`endif
        next_cycle();
        #1 check("final_idle", O_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It drives the `stall` and `flush` inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch squashes, fetch and memory wait states, and a fixed-latency multi-cycle multiply/divide occupying EX. It sits beside the datapath and owns no datapath state; its only state is the multiply/divide sequencer.

## Interface
Parameters:
- `MULDIV_CYCLES`, default 4: total EX occupancy of a mul/div instruction. Legal range is 2..16.

Ports:
- `clk`, in, 1: single pipeline clock. All state is updated on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `id_rs`, `id_rt`, in, 5 each: source register indices of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`, in, 1 each: the ID instruction actually reads that source.
- `id_muldiv`, in, 1: the ID instruction is a mul/div.
- `ex_rd`, in, 5: destination register of the instruction in EX.
- `ex_is_load`, in, 1: the EX instruction is a load.
- `ex_branch_taken`, in, 1: a branch or jump resolved taken in EX this cycle.
- `if_busy`, in, 1: instruction fetch is not complete this cycle.
- `mem_busy`, in, 1: data memory access is not complete this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, out, 1 each: hold the corresponding register.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`, out, 1 each: load a bubble into the corresponding register.
- `muldiv_busy`, out, 1: the sequencer is in ST_MULDIV.

## Operation
- Load-use hazard: `lu = ex_is_load & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd))`.
- Sequencer states:
  - ST_RUN → ST_MULDIV when `id_muldiv` is set and ID advances this cycle (no stall or flush of IF/ID→ID/EX). On entry, `cnt <= MULDIV_CYCLES-1`.
  - ST_MULDIV: `cnt` decrements each cycle unless `mem_busy` is high. When `cnt == 0`, the next state is ST_RUN.
  - `md = (state == ST_MULDIV) & (cnt != 0)`.
- Priority rules, highest first. The first matching rule defines all outputs; any output not named is 0.
  1. `mem_busy`: `pc_stall`, `if_id_stall`, `id_ex_stall` and `ex_mem_stall` high, and `mem_wb_flush` high.
  2. `md`: `pc_stall`, `if_id_stall` and `id_ex_stall` high, and `ex_mem_flush` high.
  3. `ex_branch_taken`: `if_id_flush` and `id_ex_flush` high, `pc_stall` low. The branch squashes a coincident load-use hazard.
  4. `lu`: `pc_stall` and `if_id_stall` high, and `id_ex_flush` high.
  5. `if_busy`: `pc_stall` high and `if_id_flush` high.
- A stall and a flush are never asserted together on the same register.
- While `rst` is high, every output is 0, `state` = ST_RUN and `cnt` = 0.

## Timing
- Hazard outputs are combinational from the inputs and the registered state, with zero-cycle latency. The pipeline registers sample them on the same edge.
- Load-use costs exactly 1 bubble cycle. On the next cycle the load has left EX, so `lu` drops.
- Mul/div costs `MULDIV_CYCLES-1` stall cycles after it enters EX, plus any cycles where `mem_busy` is high (those freeze the countdown).
- A taken branch costs 2 squashed slots with no stall cycle.
- Reset asserted mid-mul/div aborts the operation immediately and asynchronously. The block returns to ST_RUN with no residual stall.

## Configuration
- `PIPE_PERF_CNT_EN` defined: the block adds output ports `perf_stall_cycles` (32 bits) and `perf_flush_cycles` (32 bits).
  - `perf_stall_cycles` increments on every cycle where `pc_stall` is high.
  - `perf_flush_cycles` increments on every cycle where any flush is high.
  - Both reset to 0 and wrap modulo 2^32.
- `PIPE_PERF_CNT_EN` undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - state encoding `ST_RUN` = 1'b0, `ST_MULDIV` = 1'b1;
  - `REG_IDX_W` = 5;
  - `MULDIV_CYCLES_DFLT` = 4.
- Sub-module `load_use_detect` is purely combinational. Inputs are `id_rs`/`id_rt`/`id_uses_*`/`ex_rd`/`ex_is_load`; output is `lu`. The top level holds the sequencer, counter, priority encoder and perf counters.

## Test plan
- `ex_is_load=1`, `ex_rd=5`, `id_rs=5`, `id_uses_rs=1` for 1 cycle → `pc_stall=1`, `if_id_stall=1`, `id_ex_flush=1` for exactly 1 cycle. The same stimulus with `ex_rd=0` → no outputs.
- `id_muldiv=1` advancing with `MULDIV_CYCLES=4` → `muldiv_busy` high for 4 cycles, and `pc_stall`/`ex_mem_flush` high for the first 3 of those cycles, then ST_RUN.
- Mul/div in progress with `mem_busy=1` for 2 cycles at `cnt=2` → `ex_mem_stall`/`mem_wb_flush` high for those 2 cycles, `cnt` holds at 2, and 2 more mul/div stall cycles follow.
- `ex_branch_taken=1` together with a load-use match → `if_id_flush=1`, `id_ex_flush=1`, `pc_stall=0`, `if_id_stall=0`.
- `if_busy=1` for 3 cycles with no other hazard → `pc_stall=1` and `if_id_flush=1` for 3 cycles. `if_busy` together with load-use → the load-use rule wins (`if_id_stall=1`, `if_id_flush=0`).
- `rst` asserted during cycle 2 of a mul/div → all outputs 0 immediately and `muldiv_busy=0`. With `PIPE_PERF_CNT_EN`: the counters read 0 after reset and count 1 per stall cycle afterwards.
